// File: rtl/multicycle_rv32i.sv
// multicycle_rv32i -- multi-cycle RV32I/RV32E core with one shared memory port.
//
// Each instruction is fetched over the shared port (FETCH), then decoded and
// executed in a single cycle (EXEC). Loads and stores make one more request
// (MEM). SYSTEM instructions and illegal encodings stop the core (HALT) until
// reset.
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset.
//   NUM_REGS      32 (RV32I) or 16 (RV32E).
//
// Ports:
//   clk, reset            clock; active-low synchronous reset
//   mem_valid/mem_ready   request handshake; read data valid with mem_ready
//   mem_addr              word-aligned byte address
//   mem_wstrb             byte write enables (0 = read)
//   mem_wdata/mem_rdata   store data (lane-aligned) / read data
//   mem_instr             request is an instruction fetch
//   retire, retire_pc     one-cycle pulse per completed instruction and its PC
//   halted                sticky stop flag
//
// Build option:
//   MULTICYCLE_RV32I_MISALIGN_TRAP_EN  when defined, misaligned data accesses
//   and misaligned control-transfer targets halt the core. When undefined,
//   data addresses are masked to the access size and control targets are
//   accepted (fetch ignores pc[1:0]).
module multicycle_rv32i #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_instr,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        halted
);

  localparam int unsigned AW    = (NUM_REGS == 16) ? 4 : 5;
  localparam logic        RV32E = (NUM_REGS == 16);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [1:0]  ea_lo_q;
  logic [31:0] regs_q [NUM_REGS];

  logic        mem_valid_q, mem_instr_q, retire_q, halted_q;
  logic [31:0] mem_addr_q, mem_wdata_q, retire_pc_q;
  logic [3:0]  mem_wstrb_q;

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_instr = mem_instr_q;
  assign retire    = retire_q;
  assign retire_pc = retire_pc_q;
  assign halted    = halted_q;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'h000};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // x0 is never written, so its entry stays at its reset value of zero.
  assign rs1_val = regs_q[rs1[AW-1:0]];
  assign rs2_val = regs_q[rs2[AW-1:0]];

  // ALU
  logic [31:0] op2, alu_res;
  logic [4:0]  shamt;

  always_comb begin
    op2   = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt = op2[4:0];
    unique case (f3)
      3'b000:  alu_res = (opcode == OPC_OP && ir_q[30]) ? rs1_val - op2 : rs1_val + op2;
      3'b001:  alu_res = rs1_val << shamt;
      3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(op2)};
      3'b011:  alu_res = {31'b0, rs1_val < op2};
      3'b100:  alu_res = rs1_val ^ op2;
      3'b101:  alu_res = ir_q[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110:  alu_res = rs1_val | op2;
      default: alu_res = rs1_val & op2;
    endcase
  end

  // Decode / execute
  logic        illegal, is_sys, is_load, is_store, wr_en, ctrl;
  logic        use_rd, use_rs1, use_rs2, take;
  logic [31:0] wr_val, pc_next_d;
  logic [31:0] ea_raw, ea_d, st_data_d;
  logic [3:0]  st_strb_d;
  logic        mem_mis, ctrl_mis, trap;

  always_comb begin
    illegal   = 1'b0;
    is_sys    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    wr_en     = 1'b0;
    ctrl      = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    take      = 1'b0;
    wr_val    = alu_res;
    pc_next_d = pc_q + 32'd4;

    unique case (opcode)
      OPC_LUI: begin
        use_rd = 1'b1; wr_en = 1'b1; wr_val = imm_u;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; wr_en = 1'b1; wr_val = pc_q + imm_u;
      end
      OPC_JAL: begin
        use_rd = 1'b1; wr_en = 1'b1; wr_val = pc_q + 32'd4;
        ctrl = 1'b1; pc_next_d = pc_q + imm_j;
      end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wr_en = 1'b1; wr_val = pc_q + 32'd4;
        illegal = (f3 != 3'b000);
        ctrl = 1'b1; pc_next_d = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        unique case (f3)
          3'b000:  take = (rs1_val == rs2_val);
          3'b001:  take = (rs1_val != rs2_val);
          3'b100:  take = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  take = (rs1_val <  rs2_val);
          3'b111:  take = (rs1_val >= rs2_val);
          default: illegal = 1'b1;
        endcase
        if (take) begin
          ctrl = 1'b1; pc_next_d = pc_q + imm_b;
        end
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; is_load = 1'b1;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1;
        illegal = (f3[2] || f3[1:0] == 2'b11);
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wr_en = 1'b1;
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wr_en = 1'b1;
        if (f7 == 7'b0100000) illegal = !(f3 == 3'b000 || f3 == 3'b101);
        else                  illegal = (f7 != 7'b0000000);
      end
      OPC_FENCE:  illegal = (f3 != 3'b000);
      OPC_SYSTEM: is_sys = 1'b1;
      default:    illegal = 1'b1;
    endcase

    if (RV32E && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
      illegal = 1'b1;
  end

  // Effective address, alignment handling and store lane placement
  always_comb begin
    ea_raw = rs1_val + (is_store ? imm_s : imm_i);
`ifdef MULTICYCLE_RV32I_MISALIGN_TRAP_EN
    ea_d     = ea_raw;
    mem_mis  = (f3[1:0] == 2'b01 && ea_raw[0]) || (f3[1:0] == 2'b10 && ea_raw[1:0] != 2'b00);
    ctrl_mis = ctrl && (pc_next_d[1:0] != 2'b00);
`else
    unique case (f3[1:0])
      2'b01:   ea_d = ea_raw & ~32'd1;
      2'b10:   ea_d = ea_raw & ~32'd3;
      default: ea_d = ea_raw;
    endcase
    mem_mis  = 1'b0;
    ctrl_mis = 1'b0;
`endif
    unique case (f3[1:0])
      2'b00: begin
        st_strb_d = 4'b0001 << ea_d[1:0];
        st_data_d = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        st_strb_d = 4'b0011 << {ea_d[1], 1'b0};
        st_data_d = {2{rs2_val[15:0]}};
      end
      default: begin
        st_strb_d = 4'b1111;
        st_data_d = rs2_val;
      end
    endcase
    trap = illegal || ((is_load || is_store) && mem_mis) || ctrl_mis;
  end

  // Load lane extraction
  logic [31:0] lane, ld_val;

  always_comb begin
    lane = mem_rdata >> {ea_lo_q, 3'b000};
    unique case (f3)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_val = {24'h000000, lane[7:0]};
      3'b101:  ld_val = {16'h0000, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  // Control FSM with registered memory-port and status outputs. The next
  // request is launched on the same edge that enters FETCH/MEM, so mem_valid
  // is high for the whole state and low during EXEC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_VECTOR;
      ir_q        <= '0;
      ea_lo_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      retire_q    <= 1'b0;
      retire_pc_q <= '0;
      halted_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      unique case (state_q)
        FETCH: begin
          if (!mem_valid_q) begin
            // first fetch after reset
            mem_valid_q <= 1'b1;
            mem_instr_q <= 1'b1;
            mem_addr_q  <= {pc_q[31:2], 2'b00};
            mem_wstrb_q <= '0;
          end else if (mem_ready) begin
            ir_q        <= mem_rdata;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          if (trap) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else if (is_sys) begin
            retire_q    <= 1'b1;
            retire_pc_q <= pc_q;
            halted_q    <= 1'b1;
            state_q     <= HALT;
          end else if (is_load || is_store) begin
            ea_lo_q     <= ea_d[1:0];
            mem_valid_q <= 1'b1;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= {ea_d[31:2], 2'b00};
            mem_wstrb_q <= is_store ? st_strb_d : 4'b0000;
            mem_wdata_q <= st_data_d;
            state_q     <= MEM;
          end else begin
            if (wr_en && rd != 5'd0) regs_q[rd[AW-1:0]] <= wr_val;
            pc_q        <= pc_next_d;
            retire_q    <= 1'b1;
            retire_pc_q <= pc_q;
            mem_valid_q <= 1'b1;
            mem_instr_q <= 1'b1;
            mem_addr_q  <= {pc_next_d[31:2], 2'b00};
            mem_wstrb_q <= '0;
            state_q     <= FETCH;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (mem_wstrb_q == 4'b0000 && rd != 5'd0) regs_q[rd[AW-1:0]] <= ld_val;
            pc_q        <= pc_q + 32'd4;
            retire_q    <= 1'b1;
            retire_pc_q <= pc_q;
            mem_valid_q <= 1'b1;
            mem_instr_q <= 1'b1;
            mem_addr_q  <= {pc_q[31:2] + 30'd1, 2'b00};
            mem_wstrb_q <= '0;
            state_q     <= FETCH;
          end
        end
        default: begin
          mem_valid_q <= 1'b0;
          halted_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_rv32i.sv
module tb_multicycle_rv32i;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_instr;
  logic        retire;
  logic [31:0] retire_pc;
  logic        halted;

  multicycle_rv32i #(.RESET_VECTOR(32'h0000_0000), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_instr(mem_instr), .retire(retire), .retire_pc(retire_pc), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [6:0] LOAD = 7'h03, OPIMM = 7'h13, AUIPC = 7'h17, LUI = 7'h37, JALR = 7'h67;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Memory model: 1 KB, configurable wait states, logs of retirements and writes
  logic [31:0] mem [256];
  int unsigned stall = 0;
  int unsigned wait_cnt = 0;
  int          cyc = 0;
  bit          in_req = 0;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_strb;
  logic        h_instr;
  logic [31:0] rpc_q[$];
  int          rcyc_q[$];
  logic [31:0] wa_q[$], wd_q[$];
  logic [3:0]  ws_q[$];
  int          n_dreq = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (retire) begin
        rpc_q.push_back(retire_pc);
        rcyc_q.push_back(cyc);
      end
      if (mem_valid) begin
        if (in_req) begin
          check("hold_addr", mem_addr, h_addr);
          check("hold_strb", {28'b0, mem_wstrb}, {28'b0, h_strb});
          check("hold_data", mem_wdata, h_data);
          check("hold_instr", {31'b0, mem_instr}, {31'b0, h_instr});
        end else begin
          in_req = 1; h_addr = mem_addr; h_strb = mem_wstrb; h_data = mem_wdata; h_instr = mem_instr;
        end
        if (wait_cnt >= stall) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_ready) begin
          if (!mem_instr) n_dreq++;
          if (mem_wstrb != 4'b0000) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            wa_q.push_back(mem_addr); ws_q.push_back(mem_wstrb); wd_q.push_back(mem_wdata);
          end
          in_req = 0;
          wait_cnt = 0;
        end
      end else begin
        mem_ready = 1'b0;
        in_req = 0;
        wait_cnt = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic clear_logs();
    rpc_q.delete(); rcyc_q.delete(); wa_q.delete(); ws_q.delete(); wd_q.delete();
    n_dreq = 0;
  endtask

  // Reset, release, then run until halted or the cycle budget runs out.
  task automatic run(input int unsigned st, input int max_cyc);
    bit done;
    stall = st;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 1'b1;
    done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (halted) done = 1;
    end
    @(negedge clk);
    check("run_halts", {31'b0, done}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a, b, op, exp3, exp4;
    int          nret;
  } vec_t;

  function automatic vec_t mkv(input string n, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] op, input logic [31:0] e3, input logic [31:0] e4, input int r);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.op = op; v.exp3 = e3; v.exp4 = e4; v.nret = r;
    return v;
  endfunction

  vec_t vt[23];

  task automatic scenario1(input int unsigned st, input int gap);
    clear_mem();
    mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPIMM);
    mem[1] = enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, OPIMM);
    mem[2] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3] = enc_i(12'h401, 5'd2, 3'b101, 5'd4, OPIMM);
    for (int i = 1; i <= 4; i++) mem[3+i] = enc_s(12'(12'h100 + 4*i), 5'(i), 5'd0, 3'b010);
    mem[8] = EBREAK;
    run(st, 500);
    check("s1_x1", mem[65], 32'd5);
    check("s1_x2", mem[66], 32'hFFFF_FFFE);
    check("s1_x3", mem[67], 32'd7);
    check("s1_x4", mem[68], 32'hFFFF_FFFF);
    check("s1_nret", rpc_q.size(), 32'd9);
    if (rpc_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("s1_rpc", rpc_q[i], 32'(4*i));
      for (int i = 1; i < 4; i++) check("s1_gap", 32'(rcyc_q[i] - rcyc_q[i-1]), 32'(gap));
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);

    // ALU / branch / jump table: x1=mem[0x200], x2=mem[0x204], op at pc 8,
    // ADDI x4,x0,1 at pc 12 (skipped by taken control transfers).
    vt[0]  = mkv("add",   32'h7FFF_FFFF, 32'd1, enc_r(7'h00, 2, 1, 3'd0, 3), 32'h8000_0000, 1, 7);
    vt[1]  = mkv("sub",   32'd5, 32'd7, enc_r(7'h20, 2, 1, 3'd0, 3), 32'hFFFF_FFFE, 1, 7);
    vt[2]  = mkv("sll",   32'd1, 32'h23, enc_r(7'h00, 2, 1, 3'd1, 3), 32'd8, 1, 7);
    vt[3]  = mkv("srl",   32'h8000_0000, 32'd31, enc_r(7'h00, 2, 1, 3'd5, 3), 32'd1, 1, 7);
    vt[4]  = mkv("sra",   32'h8000_0000, 32'd4, enc_r(7'h20, 2, 1, 3'd5, 3), 32'hF800_0000, 1, 7);
    vt[5]  = mkv("slt",   32'hFFFF_FFFF, 32'd1, enc_r(7'h00, 2, 1, 3'd2, 3), 32'd1, 1, 7);
    vt[6]  = mkv("sltu",  32'hFFFF_FFFF, 32'd1, enc_r(7'h00, 2, 1, 3'd3, 3), 32'd0, 1, 7);
    vt[7]  = mkv("xor",   32'hF0F0_F0F0, 32'hFF00_FF00, enc_r(7'h00, 2, 1, 3'd4, 3), 32'h0FF0_0FF0, 1, 7);
    vt[8]  = mkv("or",    32'hF0F0_F0F0, 32'hFF00_FF00, enc_r(7'h00, 2, 1, 3'd6, 3), 32'hFFF0_FFF0, 1, 7);
    vt[9]  = mkv("and",   32'hF0F0_F0F0, 32'hFF00_FF00, enc_r(7'h00, 2, 1, 3'd7, 3), 32'hF000_F000, 1, 7);
    vt[10] = mkv("addi",  32'd0, 32'd0, enc_i(12'hFFF, 1, 3'd0, 3, OPIMM), 32'hFFFF_FFFF, 1, 7);
    vt[11] = mkv("sltiu", 32'd5, 32'd0, enc_i(12'hFFF, 1, 3'd3, 3, OPIMM), 32'd1, 1, 7);
    vt[12] = mkv("srai",  32'hFFFF_FFFE, 32'd0, enc_i(12'h401, 1, 3'd5, 3, OPIMM), 32'hFFFF_FFFF, 1, 7);
    vt[13] = mkv("xori",  32'h1234_5678, 32'd0, enc_i(12'hFFF, 1, 3'd4, 3, OPIMM), 32'hEDCB_A987, 1, 7);
    vt[14] = mkv("lui",   32'd0, 32'd0, enc_u(20'hABCDE, 3, LUI), 32'hABCD_E000, 1, 7);
    vt[15] = mkv("auipc", 32'd0, 32'd0, enc_u(20'h00001, 3, AUIPC), 32'h0000_1008, 1, 7);
    vt[16] = mkv("bltu_t", 32'h8000_0000, 32'd1, enc_b(13'd8, 1, 2, 3'd6), 32'd0, 0, 6);
    vt[17] = mkv("blt_nt", 32'h8000_0000, 32'd1, enc_b(13'd8, 1, 2, 3'd4), 32'd0, 1, 7);
    vt[18] = mkv("beq_t",  32'd3, 32'd3, enc_b(13'd8, 2, 1, 3'd0), 32'd0, 0, 6);
    vt[19] = mkv("bne_nt", 32'd3, 32'd3, enc_b(13'd8, 2, 1, 3'd1), 32'd0, 1, 7);
    vt[20] = mkv("bge_t",  32'hFFFF_FFFF, 32'hFFFF_FFFF, enc_b(13'd8, 2, 1, 3'd5), 32'd0, 0, 6);
    vt[21] = mkv("bgeu_nt", 32'd1, 32'hFFFF_FFFF, enc_b(13'd8, 2, 1, 3'd7), 32'd0, 1, 7);
    vt[22] = mkv("jal",    32'd0, 32'd0, enc_j(21'd8, 3), 32'h0000_000C, 0, 6);

    for (int v = 0; v < 23; v++) begin
      clear_mem();
      mem[0] = enc_i(12'h200, 0, 3'b010, 1, LOAD);
      mem[1] = enc_i(12'h204, 0, 3'b010, 2, LOAD);
      mem[2] = vt[v].op;
      mem[3] = enc_i(12'd1, 0, 3'b000, 4, OPIMM);
      mem[4] = enc_s(12'h208, 3, 0, 3'b010);
      mem[5] = enc_s(12'h20C, 4, 0, 3'b010);
      mem[6] = EBREAK;
      mem[128] = vt[v].a;
      mem[129] = vt[v].b;
      mem[130] = 32'hDEAD_BEEF;
      mem[131] = 32'hDEAD_BEEF;
      run(0, 200);
      check({vt[v].name, "_x3"}, mem[130], vt[v].exp3);
      check({vt[v].name, "_x4"}, mem[131], vt[v].exp4);
      check({vt[v].name, "_nret"}, rpc_q.size(), 32'(vt[v].nret));
    end

    // Basic program, zero wait states then three stall cycles per request
    scenario1(0, 2);
    scenario1(3, 5);

    // Stores and loads of every width
    clear_mem();
    mem[0]  = enc_i(12'd5, 0, 3'b000, 1, OPIMM);
    mem[1]  = enc_i(12'hFF9, 1, 3'b000, 2, OPIMM);
    mem[2]  = enc_s(12'd0, 2, 0, 3'b010);
    mem[3]  = enc_i(12'd3, 0, 3'b000, 5, LOAD);
    mem[4]  = enc_i(12'd3, 0, 3'b100, 6, LOAD);
    mem[5]  = enc_s(12'd2, 1, 0, 3'b001);
    mem[6]  = enc_i(12'd0, 0, 3'b010, 7, LOAD);
    mem[7]  = enc_s(12'h100, 5, 0, 3'b010);
    mem[8]  = enc_s(12'h104, 6, 0, 3'b010);
    mem[9]  = enc_s(12'h108, 7, 0, 3'b010);
    mem[10] = EBREAK;
    run(0, 300);
    check("ls_nwr", wa_q.size(), 32'd5);
    if (wa_q.size() == 5) begin
      check("sw_addr", wa_q[0], 32'd0);
      check("sw_strb", {28'b0, ws_q[0]}, 32'hF);
      check("sw_data", wd_q[0], 32'hFFFF_FFFE);
      check("sh_addr", wa_q[1], 32'd0);
      check("sh_strb", {28'b0, ws_q[1]}, 32'hC);
      check("sh_data", wd_q[1], 32'h0005_0005);
    end
    check("lb_x5",  mem[64], 32'hFFFF_FFFF);
    check("lbu_x6", mem[65], 32'h0000_00FF);
    check("lw_x7",  mem[66], 32'h0005_FFFE);

    // JALR with odd base: target clears bit 0, link is old pc+4
    clear_mem();
    mem[0]  = enc_i(12'h101, 0, 3'b000, 1, OPIMM);
    mem[1]  = enc_i(12'd0, 1, 3'b000, 1, JALR);
    mem[64] = enc_s(12'h180, 1, 0, 3'b010);
    mem[65] = EBREAK;
    run(0, 200);
    check("jalr_link", mem[96], 32'd8);
    check("jalr_nret", rpc_q.size(), 32'd4);
    if (rpc_q.size() == 4) begin
      check("jalr_rpc2", rpc_q[2], 32'h100);
      check("jalr_rpc3", rpc_q[3], 32'h104);
    end

    // Reset during an outstanding load
    clear_mem();
    for (int i = 1; i < 32; i++) mem[i-1] = enc_i(12'(i), 0, 3'b000, 5'(i), OPIMM);
    mem[31] = enc_i(12'h200, 0, 3'b010, 1, LOAD);
    stall = 3;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (mem_valid && !mem_instr) ok = 1;
    end
    check("rl_load_seen", {31'b0, ok}, 32'd1);
    for (int i = 1; i < 32; i++) begin
      mem[i-1] = enc_s(12'(12'h300 + 4*i), 5'(i), 0, 3'b010);
      mem[192+i] = 32'hDEAD_BEEF;
    end
    mem[31] = EBREAK;
    reset = 1'b0;
    @(negedge clk);
    check("rl_valid_low", {31'b0, mem_valid}, 32'd0);
    check("rl_retire_low", {31'b0, retire}, 32'd0);
    clear_logs();
    reset = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (mem_valid) ok = 1;
    end
    check("rl_fetch_seen", {31'b0, ok}, 32'd1);
    check("rl_fetch_addr", mem_addr, 32'h0);
    check("rl_fetch_instr", {31'b0, mem_instr}, 32'd1);
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (halted) ok = 1;
    end
    @(negedge clk);
    check("rl_halts", {31'b0, ok}, 32'd1);
    for (int i = 1; i < 32; i++) check("rl_reg_zero", mem[192+i], 32'd0);
    check("rl_nret", rpc_q.size(), 32'd32);

    // Illegal all-zero word halts without retiring
    clear_mem();
    mem[0] = enc_i(12'd1, 0, 3'b000, 1, OPIMM);
    mem[1] = 32'h0000_0000;
    run(0, 100);
    repeat (5) @(negedge clk);
    check("ill_nret", rpc_q.size(), 32'd1);
    check("ill_halted", {31'b0, halted}, 32'd1);
    check("ill_valid", {31'b0, mem_valid}, 32'd0);

    // Misaligned word load from ea=2
    clear_mem();
    mem[0] = enc_i(12'd2, 0, 3'b010, 1, LOAD);
    mem[1] = enc_s(12'h100, 1, 0, 3'b010);
    mem[2] = EBREAK;
    run(0, 100);
`ifdef MULTICYCLE_RV32I_MISALIGN_TRAP_EN
    check("mis_nret", rpc_q.size(), 32'd0);
    check("mis_ndreq", n_dreq, 32'd0);
`else
    check("mis_nret", rpc_q.size(), 32'd3);
    check("mis_data", mem[64], 32'h0020_2083);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
